// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register command sequencer:
// command opcodes, register mode selects and the sequencer state set.
package usr_pkg;

    // Command opcodes as presented on cmd_op
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    // Mode select understood by the downstream shift register
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/usr_shift_cnt.sv
// Down-counter holding the remaining shift operations of the current command.
// Saturates at zero so a stray decrement can never wrap to a long run.
module usr_shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one  = (cnt_q == CNT_W'(1));
    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for a 4-bit universal shift register. Accepts one
// LOAD/SHR/SHL/ROL command per valid/ready handshake and steps the register
// one operation per clock, finishing with a single-cycle done pulse.
// Optional abort support is compiled in when USR_CMD_ABORT_EN is defined.
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_fb,
`ifdef USR_CMD_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] par_out,
    output logic             sr_in,
    output logic             sl_in,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic             cnt_is_zero;
`ifdef USR_CMD_ABORT_EN
    logic             aborted_q, aborted_d;
`endif

    // Only the MSB of the register feeds back (rotate-left source)
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb[WIDTH-2:0];

    usr_shift_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk    (i_clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (cmd_cnt),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one),
        .is_zero  (cnt_is_zero)
    );

    // Next-state, command latch and counter control
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        fill_d   = fill_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
`ifdef USR_CMD_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    fill_d   = cmd_fill;
                    cnt_load = 1'b1;
                    if (cmd_op == OP_LOAD) begin
                        // Data only captured for LOAD so par_out keeps the
                        // last loaded value across shift commands.
                        data_d  = cmd_data;
                        state_d = ST_LOAD;
                    end else if (cmd_cnt != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
`ifdef USR_CMD_ABORT_EN
                aborted_d = abort;
`endif
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                // is_zero is a safety exit; a zero count never enters SHIFT
                if (cnt_is_one || cnt_is_zero) begin
                    state_d = ST_DONE;
`ifdef USR_CMD_ABORT_EN
                end else if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched command fields
    always_ff @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            fill_q  <= 1'b0;
`ifdef USR_CMD_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
`ifdef USR_CMD_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Register drive decoded from state and latched fields only
    always_comb begin
        sel   = SEL_HOLD;
        sr_in = 1'b0;
        sl_in = 1'b0;
        case (state_q)
            ST_LOAD: begin
                sel = SEL_LOAD;
            end
            ST_SHIFT: begin
                case (op_q)
                    OP_SHR: begin
                        sel   = SEL_SHR;
                        sr_in = fill_q;
                    end
                    OP_SHL: begin
                        sel   = SEL_SHL;
                        sl_in = fill_q;
                    end
                    OP_ROL: begin
                        sel   = SEL_SHL;
                        sl_in = q_fb[WIDTH-1];
                    end
                    default: begin
                        sel = SEL_HOLD;
                    end
                endcase
            end
            default: begin
                sel = SEL_HOLD;
            end
        endcase
    end

    assign par_out   = data_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
`ifdef USR_CMD_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Self-checking bench for usr_cmd_sequencer driving a behavioural 4-bit
// universal shift register. A queue-based model expands each accepted
// command into its expected per-cycle register drive; a compare process
// checks every cycle, and directed checks pin latencies and final Q values.
module tb_usr_cmd_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             i_clk = 1'b0;
    logic             clr = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic             cmd_fill = 1'b0;
    logic [WIDTH-1:0] q_fb;
    logic [1:0]       sel;
    logic [WIDTH-1:0] par_out;
    logic             sr_in;
    logic             sl_in;
    logic             busy;
    logic             done;
`ifdef USR_CMD_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    usr_cmd_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk     (i_clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .cmd_fill  (cmd_fill),
        .q_fb      (q_fb),
`ifdef USR_CMD_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .sel       (sel),
        .par_out   (par_out),
        .sr_in     (sr_in),
        .sl_in     (sl_in),
        .busy      (busy),
        .done      (done)
    );

    // The shift register being sequenced (environment, not a DUT model)
    logic [WIDTH-1:0] reg_q = '0;
    always @(posedge i_clk) begin
        case (sel)
            2'b01:   reg_q <= {sr_in, reg_q[WIDTH-1:1]};
            2'b10:   reg_q <= {reg_q[WIDTH-2:0], sl_in};
            2'b11:   reg_q <= par_out;
            default: reg_q <= reg_q;
        endcase
    end
    assign q_fb = reg_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // kind: 0 idle, 1 load, 2 shift, 3 done
    typedef struct packed {
        logic [1:0]       kind;
        logic [1:0]       sel;
        logic [WIDTH-1:0] par;
        logic             sr;
        logic             sl;
        logic             rol;
        logic             abrt;
    } exp_t;

    function automatic exp_t mk(input logic [1:0] k, input logic [1:0] s,
                                input logic [WIDTH-1:0] p, input logic sr,
                                input logic sl, input logic rol, input logic ab);
        exp_t e;
        e.kind = k; e.sel = s; e.par = p; e.sr = sr; e.sl = sl; e.rol = rol; e.abrt = ab;
        return e;
    endfunction

    exp_t             exp_q[$];
    exp_t             cur = '0;
    logic [WIDTH-1:0] last_par = '0;

    always @(posedge i_clk or negedge clr) begin
        if (!clr) begin
            exp_q.delete();
            cur      = '0;
            last_par = '0;
        end else begin
`ifdef USR_CMD_ABORT_EN
            if (abort && (cur.kind == 2'd1 || cur.kind == 2'd2)) begin
                if (!(cur.kind == 2'd2 && exp_q.size() > 0 && exp_q[0].kind == 2'd3)) begin
                    exp_q.delete();
                    exp_q.push_back(mk(2'd3, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b1));
                end
            end
`endif
            if (cur.kind == 2'd0 && cmd_valid) begin
                if (cmd_op == 2'b00) begin
                    exp_q.push_back(mk(2'd1, 2'b11, cmd_data, 1'b0, 1'b0, 1'b0, 1'b0));
                end else begin
                    for (int i = 0; i < int'(cmd_cnt); i++) begin
                        case (cmd_op)
                            2'b01:   exp_q.push_back(mk(2'd2, 2'b01, '0, cmd_fill, 1'b0, 1'b0, 1'b0));
                            2'b10:   exp_q.push_back(mk(2'd2, 2'b10, '0, 1'b0, cmd_fill, 1'b0, 1'b0));
                            default: exp_q.push_back(mk(2'd2, 2'b10, '0, 1'b0, 1'b0, 1'b1, 1'b0));
                        endcase
                    end
                end
                exp_q.push_back(mk(2'd3, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = '0;
            if (cur.kind == 2'd1) last_par = cur.par;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge i_clk) begin
        chk("sel",       32'(sel),       32'(cur.sel));
        chk("par_out",   32'(par_out),   32'(last_par));
        chk("sr_in",     32'(sr_in),     32'(cur.sr));
        chk("sl_in",     32'(sl_in),     32'(cur.rol ? reg_q[WIDTH-1] : cur.sl));
        chk("busy",      32'(busy),      32'(cur.kind != 2'd0));
        chk("done",      32'(done),      32'(cur.kind == 2'd3));
        chk("cmd_ready", 32'(cmd_ready), 32'(cur.kind == 2'd0));
`ifdef USR_CMD_ABORT_EN
        chk("aborted",   32'(aborted),   32'(cur.abrt));
`endif
    end

    // ---------------- directed stimulus ----------------
    logic [1:0]       first_sel;
    logic [WIDTH-1:0] first_par;

    task automatic wait_ready();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge i_clk);
            if (cmd_ready) got = 1'b1;
        end
        chk("handshake_wait", 32'(got), 32'd1);
    endtask

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d,
                        input logic [CNT_W-1:0] c, input logic f, output int lat);
        cmd_op = op; cmd_data = d; cmd_cnt = c; cmd_fill = f; cmd_valid = 1'b1;
        wait_ready();
        @(posedge i_clk);
        #1 cmd_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge i_clk);
            if (i == 1) begin
                first_sel = sel;
                first_par = par_out;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        #2 clr = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_sel",  32'(sel),     32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_done", 32'(done),    32'd0);
        chk("rst_par",  32'(par_out), 32'd0);
        clr = 1'b1;
        @(negedge i_clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        send(2'b00, 4'b1011, 3'd0, 1'b0, lat);
        $display("LOAD 1011: latency %0d Q=%b", lat, reg_q);
        chk("load_lat", 32'(lat), 32'd2);
        chk("load_sel", 32'(first_sel), 32'd3);
        chk("load_par", 32'(first_par), 32'b1011);
        chk("load_q",   32'(reg_q), 32'b1011);

        send(2'b00, 4'b0000, 3'd0, 1'b0, lat);
        $display("LOAD 0000: latency %0d Q=%b", lat, reg_q);
        chk("load0_q", 32'(reg_q), 32'd0);

        send(2'b01, 4'b0000, 3'd3, 1'b1, lat);
        $display("SHR 3 fill=1: latency %0d Q=%b", lat, reg_q);
        chk("shr_lat", 32'(lat), 32'd4);
        chk("shr_sel", 32'(first_sel), 32'd1);
        chk("shr_q",   32'(reg_q), 32'b1110);

        send(2'b00, 4'b1001, 3'd0, 1'b0, lat);
        $display("LOAD 1001: latency %0d Q=%b", lat, reg_q);
        send(2'b11, 4'b0000, 3'd5, 1'b0, lat);
        $display("ROL 5: latency %0d Q=%b", lat, reg_q);
        chk("rol_lat", 32'(lat), 32'd6);
        chk("rol_sel", 32'(first_sel), 32'd2);
        chk("rol_q",   32'(reg_q), 32'b0011);

        // SHL cnt=0 with cmd_valid held across two commands
        cmd_op = 2'b10; cmd_cnt = 3'd0; cmd_fill = 1'b1; cmd_valid = 1'b1;
        wait_ready();
        @(negedge i_clk);
        chk("zc_done1",  32'(done),      32'd1);
        chk("zc_ready1", 32'(cmd_ready), 32'd0);
        @(negedge i_clk);
        chk("zc_idle_done",  32'(done),      32'd0);
        chk("zc_idle_ready", 32'(cmd_ready), 32'd1);
        @(posedge i_clk);
        #1 cmd_valid = 1'b0;
        @(negedge i_clk);
        chk("zc_done2", 32'(done), 32'd1);
        chk("zc_q",     32'(reg_q), 32'b0011);
        $display("SHL 0 x2 back-to-back: Q=%b", reg_q);

        // Reset in the second SHIFT cycle of SHL cnt=6
        cmd_op = 2'b10; cmd_cnt = 3'd6; cmd_fill = 1'b0; cmd_valid = 1'b1;
        wait_ready();
        @(posedge i_clk);
        #1 cmd_valid = 1'b0;
        @(posedge i_clk);
        #1 clr = 1'b0;
        #1;
        chk("mr_sel",  32'(sel),  32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        clr = 1'b1;
        @(negedge i_clk);
        chk("mr_ready", 32'(cmd_ready), 32'd1);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (done) ndone++;
        end
        chk("mr_no_done", 32'(ndone), 32'd0);
        chk("mr_q", 32'(reg_q), 32'b0110);
        $display("SHL 6 reset mid-shift: Q=%b dones=%0d", reg_q, ndone);

`ifdef USR_CMD_ABORT_EN
        // Abort in the second SHIFT cycle of SHR cnt=7
        send(2'b00, 4'b0000, 3'd0, 1'b0, lat);
        cmd_op = 2'b01; cmd_cnt = 3'd7; cmd_fill = 1'b1; cmd_valid = 1'b1;
        wait_ready();
        @(posedge i_clk);
        #1 cmd_valid = 1'b0;
        @(posedge i_clk);
        #1 abort = 1'b1;
        @(posedge i_clk);
        #1 abort = 1'b0;
        @(negedge i_clk);
        chk("ab_done",    32'(done),    32'd1);
        chk("ab_aborted", 32'(aborted), 32'd1);
        chk("ab_q",       32'(reg_q),   32'b1100);
        @(negedge i_clk);
        chk("ab_done_clr",    32'(done),    32'd0);
        chk("ab_aborted_clr", 32'(aborted), 32'd0);
        $display("SHR 7 abort: Q=%b", reg_q);
`endif

        repeat (3) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
